ysyx_22041752_mem_stage: RTL and testbench

YSYX_22041752_MEM_STAGE -- requirements
Module: ysyx_22041752_mem_stage

---
 rtl/ysyx_22041752_mem_pkg.sv | 16 +
 rtl/ysyx_22041752_mem_stage_if.sv | 20 ++
 rtl/ysyx_22041752_load_ext.sv | 29 ++
 rtl/ysyx_22041752_mem_stage.sv | 95 +++++++++
 tb/tb_ysyx_22041752_mem_stage.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_22041752_mem_pkg.sv
// ysyx_22041752_mem_pkg: state encoding, load-size encodings and alignment helper for the memory stage
package ysyx_22041752_mem_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} ms_state_e;

    localparam logic [1:0] MB_1 = 2'b00;
    localparam logic [1:0] MB_2 = 2'b01;
    localparam logic [1:0] MB_4 = 2'b10;
    localparam logic [1:0] MB_8 = 2'b11;

    // On a 32-bit core an 8-byte load acts as 4-byte; both flag exactly the nonzero 2-bit offsets.
    function automatic logic misaligned(input logic [2:0] offset, input logic [1:0] bytes);
        return |(offset & 3'((4'd1 << bytes) - 4'd1));
    endfunction

endpackage

// File: rtl/ysyx_22041752_mem_stage_if.sv
// ysyx_22041752_mem_stage_if: data-memory read port between the memory stage (master) and memory (slave)
interface ysyx_22041752_mem_stage_if #(parameter int XLEN = 64);

    logic            dmem_req_valid;
    logic [XLEN-1:0] dmem_req_addr;
    logic            dmem_req_ready;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_data;

    modport master (
        output dmem_req_valid, dmem_req_addr,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_req_addr,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

endinterface

// File: rtl/ysyx_22041752_load_ext.sv
// ysyx_22041752_load_ext: pick the addressed bytes out of an aligned word and sign/zero-extend them
module ysyx_22041752_load_ext
    import ysyx_22041752_mem_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int OW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] data,
    input  logic [OW-1:0]   offset,
    input  logic [1:0]      bytes,
    input  logic            sext,
    output logic [XLEN-1:0] result
);

    logic [1:0]      eff;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top;

    // top isolates the sign bit of the selected field
    always_comb begin
        eff = (XLEN == 32 && bytes == MB_8) ? MB_4 : bytes;
        shifted = data >> {offset, 3'b000};
        keep = eff == MB_1 ? XLEN'(8'hff) : eff == MB_2 ? XLEN'(16'hffff) : eff == MB_4 ? XLEN'(32'hffff_ffff) : '1;
        top = keep ^ (keep >> 1);
        result = (shifted & keep) | ((sext && |(shifted & top)) ? ~keep : '0);
    end

endmodule

// File: rtl/ysyx_22041752_mem_stage.sv
// ysyx_22041752_mem_stage: pipeline memory stage issuing aligned loads and handing results to writeback
module ysyx_22041752_mem_stage
    import ysyx_22041752_mem_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64,
    parameter int RD_W = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ws_allowin,
    output logic                      ms_allowin,
    input  logic                      es_to_ms_valid,
    input  logic [PC_W-1:0]           es_pc,
    input  logic                      es_rf_we,
    input  logic [RD_W-1:0]           es_rd,
    input  logic [XLEN-1:0]           es_alu_result,
    input  logic                      es_mem_re,
    input  logic [1:0]                es_mem_bytes,
    input  logic                      es_res_sext,
    ysyx_22041752_mem_stage_if.master dmem,
    output logic                      ms_to_ws_valid,
    output logic                      ms_rf_we,
    output logic [RD_W-1:0]           ms_rd,
    output logic [PC_W-1:0]           ms_pc,
    output logic [XLEN-1:0]           ms_final_result,
    output logic                      ms_misalign,
    output logic                      fwd_valid,
    output logic                      fwd_pending,
    output logic [RD_W-1:0]           fwd_rd,
    output logic [XLEN-1:0]           fwd_data
);

    localparam int OW = $clog2(XLEN / 8);

    ms_state_e       state, state_n;
    logic [XLEN-1:0] alu_q, load_q, load_res;
    logic [1:0]      bytes_q;
    logic            mem_re_q, sext_q, mis_q, mis_in, capture;

    ysyx_22041752_load_ext #(.XLEN(XLEN)) u_ext (
        .data   (dmem.dmem_resp_data),
        .offset (alu_q[OW-1:0]),
        .bytes  (bytes_q),
        .sext   (sext_q),
        .result (load_res)
    );

    always_comb begin
        mis_in = misaligned(3'(es_alu_result[OW-1:0]), es_mem_bytes);
        ms_allowin = state == IDLE || (state == DONE && ws_allowin);
        capture = es_to_ms_valid && ms_allowin;
        state_n = state;
        if (capture) state_n = (es_mem_re && !mis_in) ? REQ : DONE;
        else if (state == DONE && ws_allowin) state_n = IDLE;
        else if (state == REQ && dmem.dmem_req_ready) state_n = RESP;
        else if (state == RESP && dmem.dmem_resp_valid) state_n = DONE;
    end

    // load_q is cleared on capture so a misaligned load retires with a zero result
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ms_rf_we <= 1'b0;
            mem_re_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            state <= state_n;
            if (capture) begin
                ms_pc <= es_pc;
                ms_rf_we <= es_rf_we;
                ms_rd <= es_rd;
                alu_q <= es_alu_result;
                mem_re_q <= es_mem_re;
                bytes_q <= es_mem_bytes;
                sext_q <= es_res_sext;
                mis_q <= es_mem_re && mis_in;
                load_q <= '0;
            end else if (state == RESP && dmem.dmem_resp_valid) begin
                load_q <= load_res;
            end
        end
    end

    assign ms_to_ws_valid = state == DONE;
    assign ms_misalign = ms_to_ws_valid && mis_q;
    assign ms_final_result = mem_re_q ? load_q : alu_q;
    assign fwd_valid = state != IDLE && ms_rf_we;
    assign fwd_pending = fwd_valid && mem_re_q && state != DONE;
    assign fwd_rd = ms_rd;
    assign fwd_data = ms_final_result;
    assign dmem.dmem_req_valid = state == REQ;
    assign dmem.dmem_req_addr = {alu_q[XLEN-1:OW], OW'(0)};

endmodule

// File: tb/tb_ysyx_22041752_mem_stage.sv
// tb_ysyx_22041752_mem_stage: directed scenarios plus random traffic checked against a transaction-level model
module tb_ysyx_22041752_mem_stage;

    logic        clk = 1'b0, reset = 1'b1, ws_allowin = 1'b0;
    logic        es_to_ms_valid = 1'b0, es_rf_we = 1'b0, es_mem_re = 1'b0, es_res_sext = 1'b0;
    logic [63:0] es_pc = '0, es_alu_result = '0;
    logic [4:0]  es_rd = '0;
    logic [1:0]  es_mem_bytes = '0;
    logic        ms_allowin, ms_to_ws_valid, ms_rf_we, ms_misalign, fwd_valid, fwd_pending;
    logic [4:0]  ms_rd, fwd_rd;
    logic [63:0] ms_pc, ms_final_result, fwd_data;

    int pass_cnt = 0, total = 0;
    bit chk_en = 1'b0;

    // model: an occupied slot waiting for request, then response, then writeback
    bit          m_occ = 1'b0, m_wreq = 1'b0, m_wresp = 1'b0, m_we = 1'b0, m_re = 1'b0, m_mis = 1'b0, m_sext = 1'b0;
    logic [63:0] m_pc = '0, m_addr = '0, m_res = '0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_bytes = '0;

    ysyx_22041752_mem_stage_if #(.XLEN(64)) dmem ();

    ysyx_22041752_mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_pc           (es_pc),
        .es_rf_we        (es_rf_we),
        .es_rd           (es_rd),
        .es_alu_result   (es_alu_result),
        .es_mem_re       (es_mem_re),
        .es_mem_bytes    (es_mem_bytes),
        .es_res_sext     (es_res_sext),
        .dmem            (dmem),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_rf_we        (ms_rf_we),
        .ms_rd           (ms_rd),
        .ms_pc           (ms_pc),
        .ms_final_result (ms_final_result),
        .ms_misalign     (ms_misalign),
        .fwd_valid       (fwd_valid),
        .fwd_pending     (fwd_pending),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    endtask

    task automatic chk1(input string n, input logic got, input logic exp);
        chk(n, 64'(got), 64'(exp));
    endtask

    function automatic logic [63:0] extract(input logic [63:0] d, input logic [63:0] a, input logic [1:0] b, input bit s);
        logic [63:0] w;
        w = d >> (8 * a[2:0]);
        case (b)
            2'd0:    return s ? 64'($signed(w[7:0]))  : 64'(w[7:0]);
            2'd1:    return s ? 64'($signed(w[15:0])) : 64'(w[15:0]);
            2'd2:    return s ? 64'($signed(w[31:0])) : 64'(w[31:0]);
            default: return w;
        endcase
    endfunction

    task automatic model_step();
        bit done, take;
        done = m_occ && !m_wreq && !m_wresp;
        take = es_to_ms_valid && (!m_occ || (done && ws_allowin));
        if (reset) begin
            m_occ = 1'b0;
            m_wreq = 1'b0;
            m_wresp = 1'b0;
            return;
        end
        if (m_wreq) begin
            if (dmem.dmem_req_ready) begin
                m_wreq = 1'b0;
                m_wresp = 1'b1;
            end
        end else if (m_wresp && dmem.dmem_resp_valid) begin
            m_res = extract(dmem.dmem_resp_data, m_addr, m_bytes, m_sext);
            m_wresp = 1'b0;
        end
        if (take) begin
            m_occ = 1'b1;
            m_pc = es_pc;
            m_we = es_rf_we;
            m_rd = es_rd;
            m_addr = es_alu_result;
            m_re = es_mem_re;
            m_bytes = es_mem_bytes;
            m_sext = es_res_sext;
            m_mis = es_mem_re && (es_alu_result % (64'd1 << es_mem_bytes)) != 64'd0;
            m_wreq = es_mem_re && !m_mis;
            m_wresp = 1'b0;
            m_res = es_mem_re ? 64'd0 : es_alu_result;
        end else if (done && ws_allowin) begin
            m_occ = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit done = m_occ && !m_wreq && !m_wresp;
            chk1("m_valid", ms_to_ws_valid, done);
            chk1("m_allowin", ms_allowin, !m_occ || (done && ws_allowin));
            chk1("m_req_valid", dmem.dmem_req_valid, m_wreq);
            if (m_wreq) chk("m_req_addr", dmem.dmem_req_addr, m_addr - (m_addr % 64'd8));
            chk1("m_misalign", ms_misalign, done && m_mis);
            chk1("m_fwd_valid", fwd_valid, m_occ && m_we);
            chk1("m_fwd_pending", fwd_pending, m_occ && m_we && m_re && !done);
            if (done) begin
                chk("m_result", ms_final_result, m_res);
                chk("m_fwd_data", fwd_data, m_res);
                chk("m_pc", ms_pc, m_pc);
                chk("m_rd", 64'(ms_rd), 64'(m_rd));
                chk("m_fwd_rd", 64'(fwd_rd), 64'(m_rd));
                chk1("m_rf_we", ms_rf_we, m_we);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic send(input logic [63:0] pc, input logic we, input logic [4:0] rd, input logic [63:0] alu,
                        input logic re, input logic [1:0] b, input logic s);
        es_to_ms_valid = 1'b1;
        es_pc = pc;
        es_rf_we = we;
        es_rd = rd;
        es_alu_result = alu;
        es_mem_re = re;
        es_mem_bytes = b;
        es_res_sext = s;
    endtask

    task automatic lb_case(input logic s, input logic [63:0] exp);
        dmem.dmem_req_ready = 1'b1;
        send(64'h104, 1'b1, 5'd6, 64'h1003, 1'b1, 2'd0, s);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("lb_req_valid", dmem.dmem_req_valid, 1'b1);
        chk("lb_req_addr", dmem.dmem_req_addr, 64'h1000);
        chk1("lb_pending", fwd_pending, 1'b1);
        tick();
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_resp_data = 64'h0000_0000_8000_0000;
        #1;
        chk1("lb_not_done", ms_to_ws_valid, 1'b0);
        tick();
        dmem.dmem_resp_valid = 1'b0;
        #1;
        chk1("lb_done", ms_to_ws_valid, 1'b1);
        chk("lb_result", ms_final_result, exp);
    endtask

    initial begin
        dmem.dmem_req_ready = 1'b0;
        dmem.dmem_resp_valid = 1'b0;
        dmem.dmem_resp_data = '0;
        tick();
        chk_en = 1'b1;
        tick();
        chk1("rst_valid", ms_to_ws_valid, 1'b0);
        chk1("rst_req", dmem.dmem_req_valid, 1'b0);
        chk1("rst_misalign", ms_misalign, 1'b0);
        chk1("rst_fwd_valid", fwd_valid, 1'b0);
        chk1("rst_fwd_pending", fwd_pending, 1'b0);
        chk1("rst_allowin", ms_allowin, 1'b1);
        reset = 1'b0;
        ws_allowin = 1'b1;

        send(64'h100, 1'b1, 5'd5, 64'h1234, 1'b0, 2'd0, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("alu_valid", ms_to_ws_valid, 1'b1);
        chk("alu_result", ms_final_result, 64'h1234);
        chk1("alu_pending", fwd_pending, 1'b0);
        chk("alu_fwd_rd", 64'(fwd_rd), 64'd5);

        lb_case(1'b1, 64'hFFFF_FFFF_FFFF_FF80);
        lb_case(1'b0, 64'h80);

        send(64'h108, 1'b1, 5'd8, 64'h1002, 1'b1, 2'd2, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("lw_mis_req", dmem.dmem_req_valid, 1'b0);
        chk1("lw_mis_flag", ms_misalign, 1'b1);
        chk1("lw_mis_valid", ms_to_ws_valid, 1'b1);
        chk("lw_mis_result", ms_final_result, 64'h0);
        tick();

        dmem.dmem_req_ready = 1'b0;
        send(64'h10c, 1'b1, 5'd7, 64'h2000, 1'b1, 2'd3, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("stall_req", dmem.dmem_req_valid, 1'b1);
            chk1("stall_pending", fwd_pending, 1'b1);
            tick();
        end
        dmem.dmem_req_ready = 1'b1;
        tick();
        dmem.dmem_req_ready = 1'b0;
        #1;
        chk1("resp_wait_pending", fwd_pending, 1'b1);
        chk1("resp_wait_valid", ms_to_ws_valid, 1'b0);
        tick();
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_resp_data = 64'h1122_3344_5566_7788;
        #1;
        chk1("resp_edge_pending", fwd_pending, 1'b1);
        chk1("resp_edge_valid", ms_to_ws_valid, 1'b0);
        tick();
        dmem.dmem_resp_valid = 1'b0;
        #1;
        chk1("ld_done", ms_to_ws_valid, 1'b1);
        chk("ld_result", ms_final_result, 64'h1122_3344_5566_7788);
        chk1("ld_pending", fwd_pending, 1'b0);

        ws_allowin = 1'b0;
        send(64'h200, 1'b1, 5'd9, 64'hABCD, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1("hold_allowin", ms_allowin, 1'b0);
            chk1("hold_valid", ms_to_ws_valid, 1'b1);
            chk("hold_result", ms_final_result, 64'h1122_3344_5566_7788);
            chk("hold_rd", 64'(ms_rd), 64'd7);
            tick();
        end
        ws_allowin = 1'b1;
        #1;
        chk1("b2b_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("b2b_valid", ms_to_ws_valid, 1'b1);
        chk("b2b_result", ms_final_result, 64'hABCD);
        chk("b2b_rd", 64'(ms_rd), 64'd9);
        tick();

        dmem.dmem_req_ready = 1'b1;
        send(64'h300, 1'b1, 5'd10, 64'h3000, 1'b1, 2'd3, 1'b0);
        tick();
        es_to_ms_valid = 1'b0;
        tick();
        #1;
        chk1("rresp_pending", fwd_pending, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dmem.dmem_resp_valid = 1'b1;
        dmem.dmem_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        chk1("rresp_valid", ms_to_ws_valid, 1'b0);
        chk1("rresp_fwd", fwd_valid, 1'b0);
        chk1("rresp_allowin", ms_allowin, 1'b1);
        tick();
        dmem.dmem_resp_valid = 1'b0;
        #1;
        chk1("rresp_ignored", ms_to_ws_valid, 1'b0);
        chk1("rresp_req", dmem.dmem_req_valid, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(0, 199) == 0;
            ws_allowin = $urandom_range(0, 9) < 7;
            send({32'h0, $urandom}, 1'($urandom), 5'($urandom), {$urandom, $urandom},
                 1'($urandom), 2'($urandom), 1'($urandom));
            es_to_ms_valid = $urandom_range(0, 9) < 6;
            dmem.dmem_req_ready = 1'($urandom);
            dmem.dmem_resp_valid = $urandom_range(0, 2) == 0;
            dmem.dmem_resp_data = {$urandom, $urandom};
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
